// File: rtl/img_sram_model.sv
// Cycle-accurate model of the 8-bit image SRAM macro: pipelined reads, optional
// post-reset scrub, and a registered protocol-error pulse.
module img_sram_model #(
    parameter int ROWS           = 256,
    parameter int COLS           = 256,
    parameter int READ_LAT       = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] row,
    input  logic [7:0] col,
    input  logic [7:0] din,
    input  logic       write_en,
    input  logic       sense_en,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       busy,
    output logic       err
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e        state_q;
    logic [AW-1:0] clr_addr_q;
    logic          busy_q;
    logic          err_q;

    logic [7:0]    mem   [DEPTH];
    logic          vld_q [READ_LAT];
    logic [7:0]    dat_q [READ_LAT];

    logic          in_range;
    logic          any_req;
    logic          wr_ok;
    logic          rd_ok;
    logic          err_d;
    logic          mem_we;
    logic [AW-1:0] addr;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

    // NOTE: every signal gets a value before any branch so no latch is inferred.
    always_comb begin
        in_range  = (32'(row) < 32'(ROWS)) && (32'(col) < 32'(COLS));
        addr      = AW'(32'(row) * 32'(COLS) + 32'(col));
        any_req   = write_en || sense_en;
        wr_ok     = (state_q == ST_READY) && write_en && in_range;
        rd_ok     = (state_q == ST_READY) && sense_en && !write_en;
        err_d     = 1'b0;
        case (state_q)
            ST_CLEAR: err_d = any_req;
            ST_READY: err_d = (write_en && sense_en) || (any_req && !in_range);
            default:  err_d = 1'b0;
        endcase
        mem_we    = (state_q == ST_CLEAR) || wr_ok;
        mem_addr  = (state_q == ST_CLEAR) ? clr_addr_q : addr;
        mem_wdata = (state_q == ST_CLEAR) ? 8'h00 : din;
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                ST_RESET: begin
                    clr_addr_q <= '0;
                    if (CLEAR_ON_RESET != 0) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_READY;
                    end
                end
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                ST_READY: state_q <= ST_READY;
                default:  state_q <= ST_RESET;
            endcase
        end
    end

    // NOTE: the array itself has no reset; only the scrub state machine zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Stage 0 samples the array at the request edge; later stages only shift.
    // Data registers load only on a valid beat so dout holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= 8'h00;
            end
        end else begin
            vld_q[0] <= rd_ok;
            if (rd_ok) begin
                dat_q[0] <= in_range ? mem[addr] : 8'h00;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign dout       = dat_q[READ_LAT-1];
    assign dout_valid = vld_q[READ_LAT-1];
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_img_sram_model.sv
// Directed plus randomized bench for img_sram_model against a behavioural
// array/queue model of the SRAM rules.
module tb_img_sram_model;

    localparam int ROWS     = 4;
    localparam int COLS     = 8;
    localparam int READ_LAT = 2;
    localparam int DEPTH    = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] row = '0;
    logic [7:0] col = '0;
    logic [7:0] din = '0;
    logic       write_en = 1'b0;
    logic       sense_en = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;
    logic       err;

    img_sram_model #(
        .ROWS(ROWS), .COLS(COLS), .READ_LAT(READ_LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .din(din),
        .write_en(write_en), .sense_en(sense_en), .dout(dout),
        .dout_valid(dout_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_t;

    rd_t        pend[$];
    logic [7:0] ref_mem [DEPTH];
    logic [7:0] held;
    bit         exp_err, exp_busy, first_edge;
    int         clr_left, edge_n, busy_seen;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies the SRAM rules for one sampling edge.
    task automatic model_edge(input logic we, input logic se, input logic [7:0] r,
                              input logic [7:0] c, input logic [7:0] d);
        bit inr;
        int a;
        edge_n++;
        if (first_edge) begin
            first_edge = 0;
            clr_left   = DEPTH;
            exp_err    = 0;
        end else if (clr_left > 0) begin
            ref_mem[DEPTH - clr_left] = 8'h00;
            clr_left--;
            exp_err = we || se;
        end else begin
            inr     = (r < ROWS) && (c < COLS);
            a       = inr ? (r * COLS + c) : 0;
            exp_err = (we && se) || ((we || se) && !inr);
            if (se && !we)
                pend.push_back('{edge_n + READ_LAT - 1, inr ? ref_mem[a] : 8'h00});
            if (we && inr)
                ref_mem[a] = d;
        end
        exp_busy = (clr_left > 0);
    endtask

    task automatic sample(input string tag);
        bit ev = 0;
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            ev   = 1;
            held = pend[0].data;
            void'(pend.pop_front());
        end
        check({tag, ".dout"}, dout, held);
        check({tag, ".valid"}, dout_valid, ev);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".busy"}, busy, exp_busy);
        if (busy) busy_seen++;
    endtask

    task automatic cycle(input logic we, input logic se, input logic [7:0] r,
                         input logic [7:0] c, input logic [7:0] d, input string tag);
        write_en = we; sense_en = se; row = r; col = c; din = d;
        @(posedge clk);
        model_edge(we, se, r, c, d);
        @(negedge clk);
        sample(tag);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 8'd0, 8'd0, 8'd0, "idle");
    endtask

    task automatic rd(input int r, input int c, input string tag);
        cycle(0, 1, 8'(r), 8'(c), 8'd0, tag);
    endtask

    task automatic wr(input int r, input int c, input logic [7:0] d, input string tag);
        cycle(1, 0, 8'(r), 8'(c), d, tag);
    endtask

    // Asserts reset at a falling edge, checks the reset values, releases after n cycles.
    task automatic reset_pulse(input int n);
        rst_n = 0; write_en = 0; sense_en = 0; row = 0; col = 0; din = 0;
        #1;
        check("rst.dout", dout, 8'h00);
        check("rst.valid", dout_valid, 1'b0);
        check("rst.err", err, 1'b0);
        check("rst.busy", busy, 1'b0);
        pend.delete();
        held = 8'h00; exp_err = 0; exp_busy = 0; first_edge = 1; clr_left = 0;
        busy_seen = 0;
        repeat (n) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        @(negedge clk);
        reset_pulse(2);

        // Scrub: busy for exactly DEPTH cycles, strobes during it are ignored.
        idle(1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 5)      wr(0, 0, 8'hFF, "wr_busy");
            else if (i == 9) rd(0, 1, "rd_busy");
            else             idle(1);
        end
        check("busy_len", busy_seen, DEPTH);
        idle(1);

        for (int a = 0; a < DEPTH; a++) rd(a / COLS, a % COLS, "clr_rd");
        idle(READ_LAT);

        // Write then read the next edge returns the new data.
        wr(3, 7, 8'hA5, "wr_a5");
        rd(3, 7, "rd_a5");
        idle(1);
        check("a5_direct", dout, 8'hA5);
        idle(2);
        check("a5_hold", dout, 8'hA5);

        // Read then write on the next edge returns the old data.
        wr(0, 0, 8'h11, "wr_11");
        rd(0, 0, "rd_old");
        wr(0, 0, 8'h22, "wr_22");
        check("old_direct", dout, 8'h11);
        rd(0, 0, "rd_new");
        idle(READ_LAT);
        check("new_direct", dout, 8'h22);

        // Protocol errors.
        cycle(1, 1, 8'd1, 8'd1, 8'h5A, "both");
        idle(2);
        rd(1, 1, "rd_5a");
        rd(9, 0, "rd_row9");
        rd(0, 8, "rd_col8");
        wr(9, 2, 8'h77, "wr_row9");
        idle(READ_LAT);
        check("oor_dout", dout, 8'h00);

        // Randomized traffic, including out-of-range addresses and collisions.
        repeat (300) begin
            cycle(8'($urandom_range(0, 3)) == 0, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 4)), 8'($urandom_range(0, 8)),
                  8'($urandom), "rand");
        end
        idle(READ_LAT);

        // Reads in flight are discarded by reset.
        for (int k = 0; k < 8; k++) wr(k / 2, (k * 3) % COLS, 8'(8'h80 + k), "fill");
        for (int k = 0; k < 4; k++) rd(k / 2, (k * 3) % COLS, "inflight");
        reset_pulse(2);
        idle(11);
        reset_pulse(1);
        idle(DEPTH + 1);
        check("busy_len2", busy_seen, DEPTH);
        for (int k = 0; k < 8; k++) rd(k / 2, (k * 3) % COLS, "post_scrub");
        idle(READ_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
